// File: rtl/instr_encoder_if.sv
// Handshake bundle for instr_encoder: the field-set input side and the encoded-word output side.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;

    modport master (
        output in_valid, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr
    );

    modport slave (
        input  in_valid, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr
    );
endinterface

// File: rtl/instr_encoder.sv
// RV32 R/I/S/B instruction encoder feeding a 2-entry FIFO of address-tagged words.
// Define IMM_CHECK_EN to drop and count words whose immediate does not fit the format.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    instr_encoder_if.slave bus,
    output logic           err_pulse,
    output logic [7:0]     err_count
);
    typedef enum logic [1:0] {FMT_R = 2'b00, FMT_I = 2'b01, FMT_S = 2'b10, FMT_B = 2'b11} fmt_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
    } entry_t;

    entry_t      mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic [31:0] addr_q;
    logic        ready_en;
    logic [31:0] enc_word;
    logic        imm_bad;
    logic        push;
    logic        pop;
    logic        store;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        enc_word = '0;
        case (fmt_e'(bus.fmt))
            FMT_R:   enc_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
            FMT_I:   enc_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
            FMT_S:   enc_word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode};
            FMT_B:   enc_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                                 bus.imm[4:1], bus.imm[11], bus.opcode};
            default: enc_word = '0;
        endcase
    end

    assign bus.in_ready  = ready_en && (count != 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign bus.out_instr = mem[rd_ptr].instr;
    assign bus.out_addr  = mem[rd_ptr].addr;

    assign push  = bus.in_valid && bus.in_ready;
    assign pop   = bus.out_valid && bus.out_ready;
    assign store = push && !imm_bad;

    // in_ready is held low through reset and rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    // NOTE: the two-entry store is reset so out_instr/out_addr read zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            addr_q <= BASE_ADDR;
        end else if (clear) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            addr_q <= BASE_ADDR;
        end else begin
            if (store) begin
                mem[wr_ptr] <= '{addr: addr_q, instr: enc_word};
                wr_ptr      <= ~wr_ptr;
                addr_q      <= addr_q + 32'd4;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({store, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef IMM_CHECK_EN
    logic signed [31:0] simm;
    logic               drop;

    assign simm = $signed(bus.imm);

    always_comb begin
        imm_bad = 1'b0;
        case (fmt_e'(bus.fmt))
            FMT_I, FMT_S: imm_bad = (simm < -32'sd2048) || (simm > 32'sd2047);
            FMT_B:        imm_bad = (simm < -32'sd4096) || (simm > 32'sd4094) || bus.imm[0];
            default:      imm_bad = 1'b0;
        endcase
    end

    // A word discarded by clear is not an immediate error.
    assign drop = push && imm_bad && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse <= 1'b0;
            err_count <= 8'd0;
        end else begin
            err_pulse <= drop;
            if (drop && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
        end
    end
`else
    // Upper immediate bits only matter to the range check.
    logic unused_imm;
    assign unused_imm = ^bus.imm[31:13];
    assign imm_bad    = 1'b0;
    assign err_pulse  = 1'b0;
    assign err_count  = 8'd0;
`endif
endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: vector table, hand sequences and random traffic
// checked against a queue-based reference model.
module tb_instr_encoder;
    localparam logic [31:0] BASE      = 32'h0000_0000;
    localparam logic [31:0] WRAP_BASE = 32'hFFFF_FFF8;
`ifdef IMM_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       clear  = 1'b0;
    logic       clear2 = 1'b0;
    logic       err_pulse, err_pulse2;
    logic [7:0] err_count, err_count2;

    instr_encoder_if bus ();
    instr_encoder_if bus2 ();

    instr_encoder #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus),
        .err_pulse(err_pulse), .err_count(err_count)
    );

    instr_encoder #(.BASE_ADDR(WRAP_BASE)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .clear(clear2), .bus(bus2),
        .err_pulse(err_pulse2), .err_count(err_count2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  fmt;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } fields_t;

    typedef struct {
        fields_t     f;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
    } word_t;

    word_t       q[$];
    logic [31:0] popped[$];
    logic [31:0] m_addr;
    bit          m_ready;
    bit          m_pulse;
    int          m_errc;
    int          accepted;
    fields_t     cur;
    int          checks = 0;
    int          errors = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Encoding built from bit positions with shifts and masks.
    function automatic logic [31:0] ref_enc(fields_t f);
        logic [31:0] u    = f.imm;
        logic [31:0] base = (32'(f.rs1) << 15) | (32'(f.funct3) << 12) | 32'(f.opcode);
        case (f.fmt)
            2'd0:    return base | (32'(f.funct7) << 25) | (32'(f.rs2) << 20) | (32'(f.rd) << 7);
            2'd1:    return base | ((u & 32'hFFF) << 20) | (32'(f.rd) << 7);
            2'd2:    return base | (((u >> 5) & 32'h7F) << 25) | (32'(f.rs2) << 20) | ((u & 32'h1F) << 7);
            default: return base | (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25)
                            | (32'(f.rs2) << 20) | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7);
        endcase
    endfunction

    function automatic bit ref_bad(fields_t f);
        int v = int'(f.imm);
        case (f.fmt)
            2'd1, 2'd2: return (v < -2048) || (v > 2047);
            2'd3:       return (v < -4096) || (v > 4094) || (v % 2 != 0);
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] pick_imm();
        int edges[8] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098};
        case ($urandom_range(0, 4))
            0:       return 32'($urandom_range(0, 4095)) - 32'd2048;
            1:       return 32'($urandom_range(0, 8191)) - 32'd4096;
            2:       return $urandom;
            3:       return 32'(edges[$urandom_range(0, 7)]);
            default: return 32'($urandom_range(0, 31));
        endcase
    endfunction

    task automatic drive(fields_t f, bit v);
        cur          = f;
        bus.fmt      = f.fmt;
        bus.opcode   = f.opcode;
        bus.funct3   = f.funct3;
        bus.funct7   = f.funct7;
        bus.rd       = f.rd;
        bus.rs1      = f.rs1;
        bus.rs2      = f.rs2;
        bus.imm      = f.imm;
        bus.in_valid = v;
    endtask

    // Compare DUT outputs with the model, then advance both across one rising edge.
    task automatic tick();
        bit    acc, pop, clr;
        word_t w;
        check("in_ready", 32'(bus.in_ready), 32'(m_ready && q.size() < 2));
        check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check("out_instr", bus.out_instr, q[0].instr);
            check("out_addr", bus.out_addr, q[0].addr);
        end
        check("err_pulse", 32'(err_pulse), 32'(m_pulse));
        check("err_count", 32'(err_count), 32'(m_errc));
        acc = bus.in_valid && m_ready && q.size() < 2;
        pop = (q.size() != 0) && bus.out_ready;
        clr = clear;
        if (pop && !clr) popped.push_back(bus.out_addr);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        m_pulse = 1'b0;
        if (clr) begin
            q.delete();
            m_addr = BASE;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                accepted++;
                if (CHK && ref_bad(cur)) begin
                    m_pulse = 1'b1;
                    if (m_errc < 255) m_errc++;
                end else begin
                    w.addr  = m_addr;
                    w.instr = ref_enc(cur);
                    q.push_back(w);
                    m_addr += 32'd4;
                end
            end
        end
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        clear         = 1'b0;
        rst_n         = 1'b0;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_instr", bus.out_instr, 0);
        check("rst_out_addr", bus.out_addr, 0);
        check("rst_err_pulse", 32'(err_pulse), 0);
        check("rst_err_count", 32'(err_count), 0);
        q.delete();
        popped.delete();
        m_addr   = BASE;
        m_ready  = 1'b0;
        m_pulse  = 1'b0;
        m_errc   = 0;
        accepted = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wrap_test();
        logic [31:0] want[3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        bus2.fmt       = 2'b01;
        bus2.opcode    = 7'b0010011;
        bus2.rd        = 5'd1;
        bus2.imm       = 32'd5;
        bus2.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus2.in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("wrap_addr", bus2.out_addr, want[i]);
        end
        check("wrap_instr", bus2.out_instr, 32'h00500093);
        bus2.in_valid = 1'b0;
        clear2        = 1'b1;
        @(posedge clk);
        #1;
        clear2 = 1'b0;
        check("wrap_clr_valid", 32'(bus2.out_valid), 0);
        bus2.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus2.in_valid = 1'b0;
        check("wrap_clr_addr", bus2.out_addr, WRAP_BASE);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t    vecs[9];
        fields_t f;

        vecs[0] = '{'{2'b01, 7'b0010011, 3'b000, 7'h7F, 5'd1, 5'd0, 5'd31, 32'd5},          32'h00500093};
        vecs[1] = '{'{2'b10, 7'b0100011, 3'b010, 7'h55, 5'd9, 5'd0, 5'd2,  32'd8},          32'h00202423};
        vecs[2] = '{'{2'b11, 7'b1100011, 3'b000, 7'h00, 5'd7, 5'd0, 5'd0,  32'hFFFF_FFFC},  32'hFE000EE3};
        vecs[3] = '{'{2'b00, 7'b0110011, 3'b000, 7'h00, 5'd3, 5'd1, 5'd2,  32'hDEAD_BEEF},  32'h002081B3};
        vecs[4] = '{'{2'b00, 7'b0110011, 3'b000, 7'h20, 5'd1, 5'd2, 5'd3,  32'hFFFF_FFFF},  32'h403100B3};
        vecs[5] = '{'{2'b01, 7'b0000011, 3'b010, 7'h00, 5'd5, 5'd2, 5'd0,  32'hFFFF_FFFF},  32'hFFF12283};
        vecs[6] = '{'{2'b10, 7'b0100011, 3'b010, 7'h00, 5'd0, 5'd0, 5'd2,  32'hFFFF_F800},  32'h80202023};
        vecs[7] = '{'{2'b11, 7'b1100011, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0,  32'h0000_0FFE},  32'h7E000FE3};
        vecs[8] = '{'{2'b11, 7'b1100011, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0,  32'hFFFF_F000},  32'h80000063};

        bus2.in_valid  = 1'b0;
        bus2.out_ready = 1'b0;
        bus2.fmt       = 2'b00;
        bus2.opcode    = '0;
        bus2.funct3    = '0;
        bus2.funct7    = '0;
        bus2.rd        = '0;
        bus2.rs1       = '0;
        bus2.rs2       = '0;
        bus2.imm       = '0;
        drive(vecs[0].f, 1'b0);

        do_reset();
        wrap_test();

        // Table: one word at a time, drained immediately.
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].f, 1'b1);
            tick();
            bus.in_valid = 1'b0;
            check("vec_instr", bus.out_instr, vecs[i].exp);
            check("vec_addr", bus.out_addr, BASE + 32'(i * 4));
            tick();
        end

        // S then B back to back.
        do_reset();
        bus.out_ready = 1'b1;
        drive(vecs[1].f, 1'b1);
        tick();
        check("b2b_s_instr", bus.out_instr, 32'h00202423);
        check("b2b_s_addr", bus.out_addr, BASE);
        drive(vecs[2].f, 1'b1);
        tick();
        check("b2b_b_instr", bus.out_instr, 32'hFE000EE3);
        check("b2b_b_addr", bus.out_addr, BASE + 32'd4);
        bus.in_valid = 1'b0;
        tick();

        // Backpressure: three adds offered into a stalled output.
        do_reset();
        drive(vecs[3].f, 1'b1);
        repeat (3) tick();
        check("bp_in_ready", 32'(bus.in_ready), 0);
        check("bp_hold_instr", bus.out_instr, 32'h002081B3);
        check("bp_hold_addr", bus.out_addr, BASE);
        bus.out_ready = 1'b1;
        for (int n = 0; n < 10 && accepted < 3; n++) tick();
        bus.in_valid = 1'b0;
        for (int n = 0; n < 10 && bus.out_valid; n++) tick();
        check("bp_pop_count", popped.size(), 3);
        for (int i = 0; i < 3 && i < popped.size(); i++) check("bp_pop_addr", popped[i], BASE + 32'(i * 4));

        // Clear beats a same-cycle push into a full FIFO.
        do_reset();
        drive(vecs[0].f, 1'b1);
        tick();
        tick();
        clear = 1'b1;
        drive(vecs[4].f, 1'b1);
        tick();
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        check("clr_out_valid", 32'(bus.out_valid), 0);
        bus.out_ready = 1'b1;
        drive(vecs[5].f, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        check("clr_addr", bus.out_addr, BASE);
        check("clr_instr", bus.out_instr, 32'hFFF12283);
        tick();

        // Out-of-range immediates.
        do_reset();
        bus.out_ready = 1'b1;
        f     = vecs[0].f;
        f.imm = 32'd2048;
        drive(f, 1'b1);
        tick();
        f     = vecs[2].f;
        f.imm = 32'd3;
        drive(f, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("imm_err_count", 32'(err_count), CHK ? 2 : 0);
        drive(vecs[0].f, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        check("imm_next_addr", bus.out_addr, CHK ? BASE : BASE + 32'd8);
        tick();

`ifdef IMM_CHECK_EN
        do_reset();
        bus.out_ready = 1'b1;
        f     = vecs[0].f;
        f.imm = 32'd4096;
        drive(f, 1'b1);
        repeat (260) tick();
        bus.in_valid = 1'b0;
        tick();
        check("err_saturate", 32'(err_count), 255);
`endif

        // Reset while words are buffered.
        do_reset();
        drive(vecs[3].f, 1'b1);
        tick();
        tick();
        do_reset();
        repeat (3) tick();

        // Random traffic.
        do_reset();
        for (int n = 0; n < 800; n++) begin
            f.fmt    = 2'($urandom);
            f.opcode = 7'($urandom);
            f.funct3 = 3'($urandom);
            f.funct7 = 7'($urandom);
            f.rd     = 5'($urandom);
            f.rs1    = 5'($urandom);
            f.rs2    = 5'($urandom);
            f.imm    = pick_imm();
            drive(f, $urandom_range(0, 9) < 7);
            bus.out_ready = $urandom_range(0, 9) < 6;
            clear         = $urandom_range(0, 39) == 0;
            tick();
        end
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
